decode_ctrl_pipe: RTL
=====================

DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter IW, default 16, instruction word width; legal values are 16 or more.
REQ-002 SHALL have parameter RPT_W, default 8, repeat-counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port flush  in  1  synchronous discard of all in-flight decode state.
REQ-006 SHALL have port in_valid  in  1  instruction word present.
REQ-007 SHALL have port in_word  in  IW  instruction or operand word.
REQ-008 SHALL have port in_ready  out  1  word accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port out_valid  out  1  control bundle valid.
REQ-010 SHALL have port out_ready  in  1  downstream accepts the bundle.
REQ-011 SHALL have port ctrl  out  ctrl_t  registered control bundle (treg_ld, preg_ld, acc_reset, acc_load, acc_abs, acc_en, databus_sel[1:0], mult_in_sel, alu_in_sel[1:0], acc_in_sel[2:0], ar_in_sel, data_mux_sel, dram_in_sel, dram_wr, dp_ld, pc_in_sel[1:0], alu_op[2:0]).
REQ-012 SHALL have port imm  out  IW  second word of a two-word instruction; zero otherwise.
REQ-013 SHALL have port illegal  out  1  current bundle came from an undecodable word.

Function
REQ-014 SHALL decode each word by priority: exact 16-bit match (ABS, APAC, PAC, SPAC, ZAC), then top byte (ADDH, ADDS, AND, LACK, OR, LDP, LT, LTA, MPY, RPTK, two-word ops), then top nibble (ADD, SUB, LAC).
REQ-015 SHALL treat top bytes 8'hF4 (BANZ), 8'hF8 (CALL) and 8'hF9 (B) as two-word instructions with pc_in_sel = 2'b10.
REQ-016 SHALL, for an unmatched word, emit the NOP bundle (all fields zero except pc_in_sel = 2'b11) with illegal = 1; every bundle SHALL assign every field.
REQ-017 SHALL implement FSM states IDLE, WORD2 and RPT.
REQ-018 In IDLE, an accepted single-word op SHALL give out_valid on the next cycle, a latency of 1.
REQ-019 In IDLE, an accepted two-word op SHALL latch the decoded bundle, move to WORD2 and emit nothing.
REQ-020 In WORD2, the next accepted word SHALL load imm, assert out_valid on the next cycle and return to IDLE.
REQ-021 in_ready SHALL equal (!out_valid || out_ready) in IDLE and WORD2, and SHALL be 0 in RPT.
REQ-022 out_valid, ctrl, imm and illegal SHALL hold stable while out_valid is high and out_ready is low.
REQ-023 flush SHALL clear out_valid and the repeat count and force IDLE on the next edge; it SHALL beat a simultaneous in_valid, and the word presented with it SHALL be dropped.
REQ-024 A flush while in WORD2 SHALL discard the half-received instruction without emitting a bundle.

Reset
REQ-025 On rst_n low, out_valid, ctrl, imm, illegal and the repeat count SHALL be 0 and the FSM SHALL be in IDLE, independent of clk.
REQ-026 in_ready SHALL be 1 from the first edge after reset release.

Configuration
REQ-027 With DECODE_CTRL_RPT_EN defined, RPTK (top byte 8'hCB, count k = in_word[7:0], zero-extended to RPT_W) SHALL emit no bundle and arm the count.
REQ-028 With DECODE_CTRL_RPT_EN defined, the next single-word instruction SHALL be emitted k+1 times: enter RPT, decrement on each output handshake, return to IDLE after the last one.
REQ-029 With DECODE_CTRL_RPT_EN defined, a two-word instruction following RPTK SHALL execute once, and the armed count SHALL be cleared.
REQ-030 Without DECODE_CTRL_RPT_EN, 8'hCB SHALL decode as illegal, the RPT state SHALL not exist, and the counter SHALL not be synthesised.

Structure
REQ-031 Package dsp_ctrl_pkg SHALL hold ctrl_t, the opcode constants, the two-word top-byte list and the NOP bundle constant.
REQ-032 Combinational decode SHALL live in sub-module decode_ctrl_lut (word in, ctrl_t, is_long, is_rpt, illegal out); decode_ctrl_pipe SHALL hold the FSM, registers and handshake.

Verification
REQ-033 Bench SHALL check: 16'h7F88 (ABS) with out_ready = 1 -> next cycle out_valid = 1, acc_in_sel = 3, acc_abs = 1, acc_en = 1, illegal = 0.
REQ-034 Bench SHALL check: 16'hF900 then 16'h0123 -> one bundle, pc_in_sel = 2'b10, imm = 16'h0123, one cycle after the second word.
REQ-035 Bench SHALL check: 16'h7F8E (PAC) with out_ready held 0 for 3 cycles -> bundle stable and in_ready = 0 throughout; transfer on the 4th cycle.
REQ-036 Bench SHALL check: 16'hFFFF -> NOP bundle with illegal = 1.
REQ-037 Bench SHALL check: 16'hF400 followed by flush -> no bundle emitted, FSM in IDLE, next ABS decodes normally.
REQ-038 Bench SHALL check, with DECODE_CTRL_RPT_EN: 16'hCB02 then 16'h6A05 (LT) -> three LT bundles with in_ready = 0 between them; with rst_n dropped mid-repeat -> all outputs 0 immediately.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared types and opcode constants for the DSP instruction decoder.
// ctrl_t is the registered control bundle driven into the datapath.
package dsp_ctrl_pkg;

    typedef struct packed {
        logic       treg_ld;
        logic       preg_ld;
        logic       acc_reset;
        logic       acc_load;
        logic       acc_abs;
        logic       acc_en;
        logic [1:0] databus_sel;
        logic       mult_in_sel;
        logic [1:0] alu_in_sel;
        logic [2:0] acc_in_sel;
        logic       ar_in_sel;
        logic       data_mux_sel;
        logic       dram_in_sel;
        logic       dram_wr;
        logic       dp_ld;
        logic [1:0] pc_in_sel;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam logic [15:0] OP_ABS  = 16'h7F88;
    localparam logic [15:0] OP_ZAC  = 16'h7F89;
    localparam logic [15:0] OP_PAC  = 16'h7F8E;
    localparam logic [15:0] OP_APAC = 16'h7F8F;
    localparam logic [15:0] OP_SPAC = 16'h7F90;

    localparam logic [7:0] OPB_ADDH = 8'h60;
    localparam logic [7:0] OPB_ADDS = 8'h61;
    localparam logic [7:0] OPB_LT   = 8'h6A;
    localparam logic [7:0] OPB_LTA  = 8'h6C;
    localparam logic [7:0] OPB_MPY  = 8'h6D;
    localparam logic [7:0] OPB_LDP  = 8'h6F;
    localparam logic [7:0] OPB_AND  = 8'h79;
    localparam logic [7:0] OPB_OR   = 8'h7A;
    localparam logic [7:0] OPB_LACK = 8'h7E;
    localparam logic [7:0] OPB_RPTK = 8'hCB;
    localparam logic [7:0] OPB_BANZ = 8'hF4;
    localparam logic [7:0] OPB_CALL = 8'hF8;
    localparam logic [7:0] OPB_B    = 8'hF9;

    localparam logic [3:0] OPN_ADD = 4'h0;
    localparam logic [3:0] OPN_SUB = 4'h1;
    localparam logic [3:0] OPN_LAC = 4'h2;

    localparam int N_LONG = 3;
    localparam logic [7:0] LONG_OPS [N_LONG] = '{OPB_BANZ, OPB_CALL, OPB_B};

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_PASS = 3'd4;

    localparam logic [2:0] ACC_SEL_ALU = 3'd1;
    localparam logic [2:0] ACC_SEL_P   = 3'd2;
    localparam logic [2:0] ACC_SEL_ABS = 3'd3;
    localparam logic [2:0] ACC_SEL_IMM = 3'd4;

    localparam logic [1:0] ALU_IN_DBUS  = 2'd0;
    localparam logic [1:0] ALU_IN_P     = 2'd1;
    localparam logic [1:0] ALU_IN_SHIFT = 2'd2;
    localparam logic [1:0] ALU_IN_HIGH  = 2'd3;

    localparam logic [1:0] DBUS_DRAM   = 2'd1;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b10;

    localparam ctrl_t CTRL_ZERO = '0;
    localparam ctrl_t CTRL_NOP  = '{pc_in_sel: 2'b11, default: '0};

    function automatic logic is_long_op(input logic [7:0] top);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_LONG; i++) begin
            if (top == LONG_OPS[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/decode_ctrl_lut.sv
// Combinational instruction decode: exact word, then top byte, then top nibble.
// Macro DECODE_CTRL_RPT_EN makes 8'hCB a legal RPTK prefix instead of illegal.
module decode_ctrl_lut
    import dsp_ctrl_pkg::*;
(
    input  logic [15:0] word,
    output ctrl_t       ctrl,
    output logic        is_long,
    output logic        is_rpt,
    output logic        illegal
);

    logic [7:0] top_byte;
    logic [3:0] top_nib;

    assign top_byte = word[15:8];
    assign top_nib  = word[15:12];

    always_comb begin
        ctrl    = CTRL_ZERO;
        is_long = 1'b0;
        is_rpt  = 1'b0;
        illegal = 1'b0;
        case (word)
            OP_ABS: begin
                ctrl.acc_abs    = 1'b1;
                ctrl.acc_in_sel = ACC_SEL_ABS;
                ctrl.acc_en     = 1'b1;
            end
            OP_ZAC: begin
                ctrl.acc_reset = 1'b1;
                ctrl.acc_en    = 1'b1;
            end
            OP_PAC: begin
                ctrl.acc_load   = 1'b1;
                ctrl.acc_in_sel = ACC_SEL_P;
                ctrl.acc_en     = 1'b1;
            end
            OP_APAC, OP_SPAC: begin
                ctrl.alu_in_sel = ALU_IN_P;
                ctrl.alu_op     = (word == OP_APAC) ? ALU_ADD : ALU_SUB;
                ctrl.acc_in_sel = ACC_SEL_ALU;
                ctrl.acc_en     = 1'b1;
            end
            default: begin
                if (is_long_op(top_byte)) begin
                    is_long        = 1'b1;
                    ctrl.pc_in_sel = PC_SEL_BRANCH;
                    ctrl.ar_in_sel = (top_byte == OPB_BANZ);
                    // CALL pushes the return address through the data RAM port
                    ctrl.dram_in_sel = (top_byte == OPB_CALL);
                    ctrl.dram_wr     = (top_byte == OPB_CALL);
                end else begin
                    case (top_byte)
                        OPB_ADDH, OPB_ADDS, OPB_AND, OPB_OR: begin
                            ctrl.databus_sel = DBUS_DRAM;
                            ctrl.alu_in_sel  = (top_byte == OPB_ADDH) ? ALU_IN_HIGH : ALU_IN_DBUS;
                            ctrl.alu_op      = (top_byte == OPB_AND) ? ALU_AND :
                                               (top_byte == OPB_OR)  ? ALU_OR  : ALU_ADD;
                            ctrl.acc_in_sel  = ACC_SEL_ALU;
                            ctrl.acc_en      = 1'b1;
                        end
                        OPB_LACK: begin
                            ctrl.data_mux_sel = 1'b1;
                            ctrl.acc_load     = 1'b1;
                            ctrl.acc_in_sel   = ACC_SEL_IMM;
                            ctrl.acc_en       = 1'b1;
                        end
                        OPB_LDP: begin
                            ctrl.databus_sel = DBUS_DRAM;
                            ctrl.dp_ld       = 1'b1;
                        end
                        OPB_LT: begin
                            ctrl.databus_sel = DBUS_DRAM;
                            ctrl.treg_ld     = 1'b1;
                        end
                        OPB_LTA: begin
                            ctrl.databus_sel = DBUS_DRAM;
                            ctrl.treg_ld     = 1'b1;
                            ctrl.alu_in_sel  = ALU_IN_P;
                            ctrl.alu_op      = ALU_ADD;
                            ctrl.acc_in_sel  = ACC_SEL_ALU;
                            ctrl.acc_en      = 1'b1;
                        end
                        OPB_MPY: begin
                            ctrl.databus_sel = DBUS_DRAM;
                            ctrl.mult_in_sel = 1'b1;
                            ctrl.preg_ld     = 1'b1;
                        end
                        OPB_RPTK: begin
`ifdef DECODE_CTRL_RPT_EN
                            is_rpt = 1'b1;
`else
                            ctrl    = CTRL_NOP;
                            illegal = 1'b1;
`endif
                        end
                        default: begin
                            case (top_nib)
                                OPN_ADD, OPN_SUB, OPN_LAC: begin
                                    ctrl.databus_sel = DBUS_DRAM;
                                    ctrl.alu_in_sel  = ALU_IN_SHIFT;
                                    ctrl.alu_op      = (top_nib == OPN_SUB) ? ALU_SUB :
                                                       (top_nib == OPN_LAC) ? ALU_PASS : ALU_ADD;
                                    ctrl.acc_load    = (top_nib == OPN_LAC);
                                    ctrl.acc_in_sel  = ACC_SEL_ALU;
                                    ctrl.acc_en      = 1'b1;
                                end
                                default: begin
                                    ctrl    = CTRL_NOP;
                                    illegal = 1'b1;
                                end
                            endcase
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode pipeline stage: handshake, two-word capture and optional repeat.
// Macro DECODE_CTRL_RPT_EN adds the RPTK repeat counter and RPT state.
//
// state | meaning
// IDLE  | waiting for the first word of an instruction
// WORD2 | first word of a two-word op latched, waiting for its operand
// RPT   | re-emitting the held bundle until the repeat count runs out
module decode_ctrl_pipe
    import dsp_ctrl_pkg::*;
#(
    parameter int IW    = 16,
    parameter int RPT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [IW-1:0] in_word,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output ctrl_t         ctrl,
    output logic [IW-1:0] imm,
    output logic          illegal
);

    if (IW < 16) begin : g_iw_chk
        $error("decode_ctrl_pipe: IW must be at least 16");
    end
    if (RPT_W < 8) begin : g_rpt_w_chk
        $error("decode_ctrl_pipe: RPT_W must hold an 8-bit repeat count");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WORD2 = 2'd1
`ifdef DECODE_CTRL_RPT_EN
        ,RPT  = 2'd2
`endif
    } state_t;

    state_t        state, state_nxt;
    logic          valid_nxt;
    ctrl_t         ctrl_nxt;
    logic [IW-1:0] imm_nxt;
    logic          illegal_nxt;

    ctrl_t lut_ctrl;
    logic  lut_long;
    logic  lut_rpt;
    logic  lut_illegal;

    logic accept;
    logic out_fire;

`ifdef DECODE_CTRL_RPT_EN
    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
    logic             rpt_armed, rpt_armed_nxt;
`endif

    decode_ctrl_lut u_lut (
        .word    (in_word[15:0]),
        .ctrl    (lut_ctrl),
        .is_long (lut_long),
        .is_rpt  (lut_rpt),
        .illegal (lut_illegal)
    );

    always_comb begin
        in_ready = !out_valid || out_ready;
`ifdef DECODE_CTRL_RPT_EN
        if (state == RPT) in_ready = 1'b0;
`endif
    end

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        valid_nxt   = out_valid;
        ctrl_nxt    = ctrl;
        imm_nxt     = imm;
        illegal_nxt = illegal;
`ifdef DECODE_CTRL_RPT_EN
        rpt_cnt_nxt   = rpt_cnt;
        rpt_armed_nxt = rpt_armed;
`endif
        if (out_fire) valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (lut_rpt) begin
`ifdef DECODE_CTRL_RPT_EN
                        rpt_cnt_nxt   = RPT_W'(in_word[7:0]);
                        rpt_armed_nxt = 1'b1;
`endif
                    end else if (lut_long) begin
                        ctrl_nxt    = lut_ctrl;
                        illegal_nxt = 1'b0;
                        state_nxt   = WORD2;
`ifdef DECODE_CTRL_RPT_EN
                        // repeat does not apply to two-word ops
                        rpt_cnt_nxt   = '0;
                        rpt_armed_nxt = 1'b0;
`endif
                    end else begin
                        ctrl_nxt    = lut_ctrl;
                        imm_nxt     = '0;
                        illegal_nxt = lut_illegal;
                        valid_nxt   = 1'b1;
`ifdef DECODE_CTRL_RPT_EN
                        if (rpt_armed) begin
                            rpt_armed_nxt = 1'b0;
                            state_nxt     = RPT;
                        end
`endif
                    end
                end
            end
            WORD2: begin
                if (accept) begin
                    imm_nxt   = in_word;
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
`ifdef DECODE_CTRL_RPT_EN
            RPT: begin
                if (out_fire) begin
                    if (rpt_cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt - 1'b1;
                        valid_nxt   = 1'b1;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        if (flush) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
`ifdef DECODE_CTRL_RPT_EN
            rpt_cnt_nxt   = '0;
            rpt_armed_nxt = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ctrl      <= CTRL_ZERO;
            imm       <= '0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= valid_nxt;
            ctrl      <= ctrl_nxt;
            imm       <= imm_nxt;
            illegal   <= illegal_nxt;
        end
    end

`ifdef DECODE_CTRL_RPT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt_nxt;
            rpt_armed <= rpt_armed_nxt;
        end
    end
`endif

endmodule
